ifft8_iter_core: RTL and testbench
==================================

Name: ifft8_iter_core

Overview:
- Iterative 8-point radix-2 decimation-in-frequency inverse FFT engine in signed fixed point (Qm.decimal two's complement), the inverse-direction counterpart of the team's forward butterflies.
- Samples load serially through a valid/ready stream and are held in an 8-entry register bank.
- The engine runs one inverse butterfly per cycle for 3 stages × 4 butterflies, scaling by 1/2 per stage for a total 1/N.
- Results stream out in natural order.

Parameters:
- width, 8, bit width of every real/imag sample and twiddle.
- decimal, 4, fractional bits (1.0 = 2^decimal).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine accepts an input sample.
- in_re  in  width  input real part (frequency bin, natural order).
- in_im  in  width  input imag part.
- out_valid  out  1  output sample valid.
- out_ready  in  1  sink accepts an output sample.
- out_re  out  width  output real part (time sample, natural order).
- out_im  out  width  output imag part.
- out_last  out  1  high with the 8th output sample (index 7).
- busy  out  1  high in COMPUTE or UNLOAD.

Behaviour:
- Reset (rst_n=0, asynchronous): state=LOAD, counters=0, bank cleared to 0. Output values during reset: in_ready=0, out_valid=0, out_last=0, busy=0, out_re=out_im=0.
- After reset deassert: in_ready=1 from the first clock edge.
- LOAD: in_ready=1. Each edge with in_valid&in_ready writes bank[load_idx] and increments load_idx. The 8th accept (load_idx=7) moves to COMPUTE. in_valid is ignored outside LOAD.
- COMPUTE: in_ready=0, busy=1. 12 cycles with counter c=0..11; stage s=c/4, j=c%4, h=4>>s, k=j%h, i0=(j/h)*2h+k, i1=i0+h, twiddle index t=k<<s.
- Butterfly (one per cycle, written back in place on the same edge):
  - Sums and differences use width+1 bits, then an arithmetic shift right by 1 truncates back to width.
  - bank[i0] = (a+b)>>>1.
  - d = (a-b)>>>1; bank[i1] = d × Wc[t], a complex multiply.
  - Each real product is the full 2·width product >>>decimal, keeping the low width bits. Real = dr·Wr − di·Wi; imag = dr·Wi + di·Wr. These add/subtract wrap modulo 2^width.
- Conjugated twiddles Wc[t] = cos(2πt/8) + j·sin(2πt/8), Q(decimal) truncated toward zero. For width=8, decimal=4: t0=(16,0), t1=(11,11), t2=(0,16), t3=(−11,11).
- After c=11 the engine moves to UNLOAD. out_valid rises exactly 12 edges after the edge that accepted the 8th input.
- UNLOAD:
  - out_valid=1; out_re/out_im = bank[bitrev3(out_idx)].
  - out_idx advances only on out_valid&out_ready; data holds stable while out_ready=0.
  - out_last=1 when out_idx=7. The handshake at idx 7 returns to LOAD: out_valid=0 and in_ready=1 on the next cycle.
- Back-to-back frames: there is no overlap. The next frame's loads start the cycle after the last output handshake.
- Reset mid-COMPUTE or mid-UNLOAD aborts the frame immediately. No partial output is emitted afterwards.
- Overflow: no saturation anywhere; wrap modulo 2^width.

Decomposition:
- Package ifft8_pkg holds:
  - N=8, LOG2N=3.
  - State enum {LOAD, COMPUTE, UNLOAD}.
  - Twiddle constant function (conjugated, parameterised by width/decimal).
  - bitrev3 function.
- Sub-module butterfly_dif_inv: combinational scaled inverse DIF butterfly (a, b, Wc → o0, o1). The core instantiates it once and time-multiplexes it.

Test Plan:
- Impulse: x=[16,0,0,0,0,0,0,0] (imag 0) -> 8 outputs all (2,0); out_last on the 8th; out_valid exactly 12 edges after the 8th input accept.
- DC: all 8 inputs (16,0) -> output[0]=(16,0), outputs 1..7 = (0,0).
- Bin 1: only input[1]=(16,0) -> outputs ≈ 2·(cos,sin)(2πn/8). Must equal the bit-exact golden model with the truncation rules: n0=(2,0), n2=(0,2), n4=(−2,0), n6=(0,−2); n1, n3, n5, n7 magnitude 1 each part, signs per quadrant.
- Backpressure: hold out_ready=0 for 5 cycles at idx 3 -> out_re/out_im/out_idx stable; in_ready stays 0; in_valid pulses are ignored and do not enter the bank.
- Reset mid-COMPUTE: assert rst_n=0 at c=6 -> outputs immediately at reset values. A following impulse frame must still produce all (2,0).
- Back-to-back: two frames (impulse, then DC) with in_valid held high -> each result is correct. in_ready=0 from the 8th accept until the cycle after frame 1's out_last handshake.

Source files
------------

// File: rtl/ifft8_pkg.sv
// ifft8_pkg: shared constants, FSM states and helper functions for the 8-point inverse FFT
package ifft8_pkg;
  localparam int N = 8;
  localparam int LOG2N = 3;
  typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction
  function automatic int tw_re(input int t, input int decimal);
    int r;
    r = isqrt(1 << (2 * decimal - 1));
    return t == 0 ? (1 << decimal) : t == 1 ? r : t == 2 ? 0 : -r;
  endfunction
  function automatic int tw_im(input int t, input int decimal);
    int r;
    r = isqrt(1 << (2 * decimal - 1));
    return t == 0 ? 0 : t == 2 ? (1 << decimal) : r;
  endfunction
  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction
endpackage

// File: rtl/butterfly_dif_inv.sv
// butterfly_dif_inv: scaled inverse DIF butterfly, o0=(a+b)/2, o1=((a-b)/2)*w with wrapping
module butterfly_dif_inv #(
  parameter int width = 8,
  parameter int decimal = 4
) (
  input  logic signed [width-1:0] a_re,
  input  logic signed [width-1:0] a_im,
  input  logic signed [width-1:0] b_re,
  input  logic signed [width-1:0] b_im,
  input  logic signed [width-1:0] w_re,
  input  logic signed [width-1:0] w_im,
  output logic signed [width-1:0] o0_re,
  output logic signed [width-1:0] o0_im,
  output logic signed [width-1:0] o1_re,
  output logic signed [width-1:0] o1_im
);
  logic signed [width:0] s_re, s_im, d_re, d_im;
  logic signed [width-1:0] dr, di;
  logic signed [2*width-1:0] p_rr, p_ii, p_ri, p_ir;
  // one extra bit for the sum/difference, halve, then full-width products rescaled by decimal
  always_comb begin
    s_re = {a_re[width-1], a_re} + {b_re[width-1], b_re};
    s_im = {a_im[width-1], a_im} + {b_im[width-1], b_im};
    d_re = {a_re[width-1], a_re} - {b_re[width-1], b_re};
    d_im = {a_im[width-1], a_im} - {b_im[width-1], b_im};
    o0_re = width'(s_re >>> 1);
    o0_im = width'(s_im >>> 1);
    dr = width'(d_re >>> 1);
    di = width'(d_im >>> 1);
    p_rr = {{width{dr[width-1]}}, dr} * {{width{w_re[width-1]}}, w_re};
    p_ii = {{width{di[width-1]}}, di} * {{width{w_im[width-1]}}, w_im};
    p_ri = {{width{dr[width-1]}}, dr} * {{width{w_im[width-1]}}, w_im};
    p_ir = {{width{di[width-1]}}, di} * {{width{w_re[width-1]}}, w_re};
    o1_re = width'(p_rr >>> decimal) - width'(p_ii >>> decimal);
    o1_im = width'(p_ri >>> decimal) + width'(p_ir >>> decimal);
  end
endmodule

// File: rtl/ifft8_iter_core.sv
// ifft8_iter_core: iterative 8-point radix-2 DIF inverse FFT with serial load/unload streams
module ifft8_iter_core import ifft8_pkg::*; #(
  parameter int width = 8,
  parameter int decimal = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [width-1:0] in_re,
  input  logic signed [width-1:0] in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [width-1:0] out_re,
  output logic signed [width-1:0] out_im,
  output logic                    out_last,
  output logic                    busy
);
  localparam logic signed [width-1:0] wr [4] = '{width'(tw_re(0, decimal)), width'(tw_re(1, decimal)),
                                                  width'(tw_re(2, decimal)), width'(tw_re(3, decimal))};
  localparam logic signed [width-1:0] wi [4] = '{width'(tw_im(0, decimal)), width'(tw_im(1, decimal)),
                                                  width'(tw_im(2, decimal)), width'(tw_im(3, decimal))};
  state_t state;
  logic [LOG2N-1:0] load_idx, out_idx;
  logic [3:0] c;
  logic signed [width-1:0] bank_re [N];
  logic signed [width-1:0] bank_im [N];
  logic [1:0] s, j, t;
  logic [2:0] i0, i1;
  logic signed [width-1:0] o0_re, o0_im, o1_re, o1_im;
  // butterfly addressing: stage s spans h=4>>s, twiddle step doubles each stage
  always_comb begin
    s = c[3:2];
    j = c[1:0];
    i0 = s == 2'd0 ? {1'b0, j} : s == 2'd1 ? {j[1], 1'b0, j[0]} : {j, 1'b0};
    i1 = i0 + (s == 2'd0 ? 3'd4 : s == 2'd1 ? 3'd2 : 3'd1);
    t = s == 2'd0 ? j : s == 2'd1 ? {j[0], 1'b0} : 2'd0;
  end
  butterfly_dif_inv #(.width(width), .decimal(decimal)) u_bfly (
    .a_re(bank_re[i0]), .a_im(bank_im[i0]), .b_re(bank_re[i1]), .b_im(bank_im[i1]),
    .w_re(wr[t]), .w_im(wi[t]),
    .o0_re(o0_re), .o0_im(o0_im), .o1_re(o1_re), .o1_im(o1_im)
  );
  assign out_re = out_valid ? bank_re[bitrev3(out_idx)] : '0;
  assign out_im = out_valid ? bank_im[bitrev3(out_idx)] : '0;
  // frame FSM: serial load, 12 in-place butterflies, bit-reversed read-out in natural order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      load_idx <= '0;
      out_idx <= '0;
      c <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      busy <= 1'b0;
      for (int n = 0; n < N; n++) begin
        bank_re[n] <= '0;
        bank_im[n] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            bank_re[load_idx] <= in_re;
            bank_im[load_idx] <= in_im;
            load_idx <= load_idx + 1'b1;
            if (load_idx == 3'd7) begin
              state <= COMPUTE;
              in_ready <= 1'b0;
              busy <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          bank_re[i0] <= o0_re;
          bank_im[i0] <= o0_im;
          bank_re[i1] <= o1_re;
          bank_im[i1] <= o1_im;
          c <= c == 4'd11 ? 4'd0 : c + 4'd1;
          if (c == 4'd11) begin
            state <= UNLOAD;
            out_valid <= 1'b1;
          end
        end
        UNLOAD: begin
          if (out_ready) begin
            out_idx <= out_idx + 1'b1;
            out_last <= out_idx == 3'd6;
            if (out_idx == 3'd7) begin
              state <= LOAD;
              out_valid <= 1'b0;
              busy <= 1'b0;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_ifft8_iter_core.sv
// tb_ifft8_iter_core: scoreboard bench against a floating-twiddle, array-based inverse FFT model
module tb_ifft8_iter_core;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, out_last, busy;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic signed [W-1:0] out_re, out_im;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_hs_cyc = 0;
  int hs_total = 0;
  bit lat_armed = 1'b0;
  int q_re[$];
  int q_im[$];
  int q_last[$];
  int wr[4], wi[4];

  ifft8_iter_core #(.width(W), .decimal(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int w8(input int v);
    return ((v + 128) & 255) - 128;
  endfunction

  function automatic void ifft_model(input int xr[8], input int xi[8], output int yr[8], output int yi[8]);
    int r[8], m[8];
    int h, i0, i1, tw, dr, di, sr, si;
    r = xr;
    m = xi;
    for (int s = 0; s < 3; s++) begin
      h = 4 >> s;
      for (int g = 0; g < 8; g += 2 * h)
        for (int k = 0; k < h; k++) begin
          i0 = g + k;
          i1 = g + k + h;
          tw = k << s;
          sr = (r[i0] + r[i1]) >>> 1;
          si = (m[i0] + m[i1]) >>> 1;
          dr = (r[i0] - r[i1]) >>> 1;
          di = (m[i0] - m[i1]) >>> 1;
          r[i0] = sr;
          m[i0] = si;
          r[i1] = w8(w8((dr * wr[tw]) >>> 4) - w8((di * wi[tw]) >>> 4));
          m[i1] = w8(w8((dr * wi[tw]) >>> 4) + w8((di * wr[tw]) >>> 4));
        end
    end
    for (int n = 0; n < 8; n++) begin
      yr[n] = r[((n & 1) << 2) | (n & 2) | ((n >> 2) & 1)];
      yi[n] = m[((n & 1) << 2) | (n & 2) | ((n >> 2) & 1)];
    end
  endfunction

  // monitor: latency of the first output, then pop-and-compare on every output handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (lat_armed && out_valid) begin
        check("latency", cyc - acc_cyc, 12);
        lat_armed = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q_re.size() == 0) check("unexpected_output", int'(out_valid), 0);
        else begin
          check("out_re", int'(out_re), q_re.pop_front());
          check("out_im", int'(out_im), q_im.pop_front());
          check("out_last", int'(out_last), q_last.pop_front());
        end
        hs_total++;
        last_hs_cyc = cyc;
      end
    end
  end

  task automatic send_frame(input int xr[8], input int xi[8], input bit hold);
    int yr[8], yi[8];
    int guard;
    bit pend;
    pend = q_re.size() != 0;
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1;
      in_re = W'(xr[n]);
      in_im = W'(xi[n]);
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check("accept_timeout", int'(in_ready), 1);
        in_valid = 1'b0;
        return;
      end
      if (pend && n == 0) check("in_ready_rise", (q_re.size() == 0 && cyc == last_hs_cyc + 1) ? 1 : 0, 1);
      if (n == 7) begin
        acc_cyc = cyc + 1;
        lat_armed = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!hold) in_valid = 1'b0;
    ifft_model(xr, xi, yr, yi);
    for (int n = 0; n < 8; n++) begin
      q_re.push_back(yr[n]);
      q_im.push_back(yi[n]);
      q_last.push_back(n == 7 ? 1 : 0);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((q_re.size() != 0 || out_valid) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (q_re.size() != 0) check("drain_timeout", q_re.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_frame(output int xr[8], output int xi[8]);
    for (int n = 0; n < 8; n++) begin
      xr[n] = int'($urandom_range(0, 255)) - 128;
      xi[n] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int imp[8], dc[8], bin1[8], zero[8], rr[8], ri[8];
    int base, guard;
    for (int t = 0; t < 4; t++) begin
      wr[t] = $rtoi(16.0 * $cos(6.283185307179586 * t / 8.0));
      wi[t] = $rtoi(16.0 * $sin(6.283185307179586 * t / 8.0));
    end
    for (int n = 0; n < 8; n++) begin
      imp[n] = n == 0 ? 16 : 0;
      dc[n] = 16;
      bin1[n] = n == 1 ? 16 : 0;
      zero[n] = 0;
    end
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_re", int'(out_re), 0);
    check("rst_out_im", int'(out_im), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_pre_edge", int'(in_ready), 0);
    @(negedge clk);
    check("in_ready_first_edge", int'(in_ready), 1);
    @(posedge clk);
    #1;
    send_frame(imp, zero, 1'b0);
    wait_drain();
    send_frame(dc, zero, 1'b0);
    wait_drain();
    send_frame(bin1, zero, 1'b0);
    wait_drain();
    for (int f = 0; f < 4; f++) begin
      rand_frame(rr, ri);
      send_frame(rr, ri, 1'b0);
      wait_drain();
    end
    rand_frame(rr, ri);
    base = hs_total;
    send_frame(rr, ri, 1'b0);
    guard = 0;
    while (hs_total < base + 3 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("bp_reach_idx3", hs_total - base, 3);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_re", int'(out_re), q_re.size() != 0 ? q_re[0] : 999);
      check("bp_im", int'(out_im), q_im.size() != 0 ? q_im[0] : 999);
      check("bp_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      in_valid = (k % 2) == 0;
      in_re = W'($urandom);
      in_im = W'($urandom);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    send_frame(imp, zero, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("busy_compute", int'(busy), 1);
    rst_n = 1'b0;
    lat_armed = 1'b0;
    q_re.delete();
    q_im.delete();
    q_last.delete();
    #1;
    check("abort_in_ready", int'(in_ready), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_last", int'(out_last), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_out_re", int'(out_re), 0);
    check("abort_out_im", int'(out_im), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(imp, zero, 1'b0);
    wait_drain();
    send_frame(imp, zero, 1'b1);
    send_frame(dc, zero, 1'b0);
    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
